// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } hazard_state_e;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_wait_timer.sv
// Consecutive memory-busy cycle counter with an expiry strobe at MEM_TIMEOUT-1.
module hazard_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLimit = CntW'(MEM_TIMEOUT - 1);
  localparam logic [CntW-1:0] CntMax   = CntW'(MEM_TIMEOUT);

  logic [CntW-1:0] r_wait_cnt;

  // Clear wins over increment; the count saturates rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_wait_cnt <= '0;
    end else if (i_inc && (r_wait_cnt != CntMax)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  assign o_expire = (r_wait_cnt == CntLimit);

endmodule

// File: rtl/hazard_unit.sv
// Load-use / branch-flush / memory-wait hazard controller with a memory timeout FSM.
// Optional stall counter enabled by defining HAZARD_STALL_CNT_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [REG_IDX_W-1:0] i_idRs,
  input  logic [REG_IDX_W-1:0] i_idRt,
  input  logic                 i_idUsesRt,
  input  logic                 i_exMemRead,
  input  logic [REG_IDX_W-1:0] i_exRt,
  input  logic                 i_branchTaken,
  input  logic                 i_memBusy,
  output logic                 o_pcWrite,
  output logic                 o_ifIdWrite,
  output logic                 o_ctrlBubble,
  output logic                 o_ifIdFlush,
  output logic                 o_pipeFreeze,
  output logic                 o_memErr,
  output logic [31:0]          o_stallCnt
);

  hazard_state_e r_state, w_state_next;
  logic          w_lu;
  logic          w_freeze;
  logic          w_expire;

  assign w_lu = i_exMemRead && (i_exRt != REG_ZERO) &&
                ((i_exRt == i_idRs) || (i_idUsesRt && (i_exRt == i_idRt)));
  assign w_freeze = i_memBusy || (r_state == TIMEOUT);

  hazard_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .i_clk   (i_clk),
    .i_clr   (i_rst || !i_memBusy),
    .i_inc   (i_memBusy && (r_state != TIMEOUT)),
    .o_expire(w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RUN:      if (i_memBusy) w_state_next = MEM_WAIT;
      MEM_WAIT: begin
        if (!i_memBusy)    w_state_next = RUN;
        else if (w_expire) w_state_next = TIMEOUT;
      end
      TIMEOUT:  w_state_next = TIMEOUT;
      default:  w_state_next = RUN;
    endcase
  end

  // Reset forces every output low in the reset cycle itself.
  always_comb begin
    o_pcWrite    = 1'b0;
    o_ifIdWrite  = 1'b0;
    o_ctrlBubble = 1'b0;
    o_ifIdFlush  = 1'b0;
    o_pipeFreeze = 1'b0;
    o_memErr     = 1'b0;
    if (!i_rst) begin
      o_memErr = (r_state == TIMEOUT);
      if (w_freeze) begin
        o_pcWrite    = 1'b1;
        o_ifIdWrite  = 1'b1;
        o_pipeFreeze = 1'b1;
      end else if (w_lu) begin
        o_pcWrite    = 1'b1;
        o_ifIdWrite  = 1'b1;
        o_ctrlBubble = 1'b1;
      end else if (i_branchTaken) begin
        o_ifIdFlush  = 1'b1;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (o_pcWrite) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stallCnt = i_rst ? 32'h0000_0000 : r_stall_cnt;
`else
  assign o_stallCnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MEM_TIMEOUT = 16).
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  idRs, idRt, exRt;
  logic        idUsesRt, exMemRead, branchTaken, memBusy;
  logic        pcWrite, ifIdWrite, ctrlBubble, ifIdFlush, pipeFreeze, memErr;
  logic [31:0] stallCnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Output vector order: pcWrite ifIdWrite ctrlBubble ifIdFlush pipeFreeze memErr
  localparam logic [5:0] ONone = 6'b000000;
  localparam logic [5:0] OFrz  = 6'b110010;
  localparam logic [5:0] OTo   = 6'b110011;
  localparam logic [5:0] OLu   = 6'b111000;
  localparam logic [5:0] OFl   = 6'b000100;

  logic [5:0] outv;
  assign outv = {pcWrite, ifIdWrite, ctrlBubble, ifIdFlush, pipeFreeze, memErr};

  always #5 clk = ~clk;

  hazard_unit #(
    .MEM_TIMEOUT(16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_idRs       (idRs),
    .i_idRt       (idRt),
    .i_idUsesRt   (idUsesRt),
    .i_exMemRead  (exMemRead),
    .i_exRt       (exRt),
    .i_branchTaken(branchTaken),
    .i_memBusy    (memBusy),
    .o_pcWrite    (pcWrite),
    .o_ifIdWrite  (ifIdWrite),
    .o_ctrlBubble (ctrlBubble),
    .o_ifIdFlush  (ifIdFlush),
    .o_pipeFreeze (pipeFreeze),
    .o_memErr     (memErr),
    .o_stallCnt   (stallCnt)
  );

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    idRs = 5'd0; idRt = 5'd0; exRt = 5'd0;
    idUsesRt = 1'b0; exMemRead = 1'b0; branchTaken = 1'b0; memBusy = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    memBusy = 1'b1; exMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8; branchTaken = 1'b1;
    tick();
    #1;
    n_checks++;
    if (outv !== ONone) $display("FAIL reset_outputs: got %b want %b", outv, ONone);
    else n_pass++;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    n_checks++;
    if (outv !== ONone) $display("FAIL post_reset_idle: got %b want %b", outv, ONone);
    else n_pass++;
    n_checks++;
    if (stallCnt !== 32'd0) $display("FAIL post_reset_stallcnt: got %0d want 0", stallCnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    exMemRead = 1'b1; exRt = 5'd8; idRs = 5'd8;
    #1;
    n_checks++;
    if (outv !== OLu) $display("FAIL load_use_rs: got %b want %b", outv, OLu);
    else n_pass++;
    tick();
    exMemRead = 1'b0;
    #1;
    n_checks++;
    if (outv !== ONone) $display("FAIL load_use_release: got %b want %b", outv, ONone);
    else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_mem_wait_short();
    for (int c = 1; c <= 3; c++) begin
      memBusy = 1'b1;
      #1;
      n_checks++;
      if (outv !== OFrz) $display("FAIL mem_wait_cycle%0d: got %b want %b", c, outv, OFrz);
      else n_pass++;
      tick();
    end
    memBusy = 1'b0;
    #1;
    n_checks++;
    if (outv !== ONone) $display("FAIL mem_wait_release: got %b want %b", outv, ONone);
    else n_pass++;
    tick();
    n_checks++;
`ifdef HAZARD_STALL_CNT_EN
    if (stallCnt !== 32'd4) $display("FAIL stall_count: got %0d want 4", stallCnt);
    else n_pass++;
`else
    if (stallCnt !== 32'd0) $display("FAIL stall_count: got %0d want 0", stallCnt);
    else n_pass++;
`endif
  endtask

  task automatic test_no_stall();
    exMemRead = 1'b1; exRt = 5'd0; idRs = 5'd0;
    #1;
    n_checks++;
    if (outv !== ONone) $display("FAIL zero_reg_no_stall: got %b want %b", outv, ONone);
    else n_pass++;
    exRt = 5'd8; idRt = 5'd8; idUsesRt = 1'b0; idRs = 5'd3;
    #1;
    n_checks++;
    if (outv !== ONone) $display("FAIL rt_unused_no_stall: got %b want %b", outv, ONone);
    else n_pass++;
    idUsesRt = 1'b1;
    #1;
    n_checks++;
    if (outv !== OLu) $display("FAIL rt_used_stall: got %b want %b", outv, OLu);
    else n_pass++;
    tick();
    idle_inputs();
  endtask

  task automatic test_branch();
    branchTaken = 1'b1;
    #1;
    n_checks++;
    if (outv !== OFl) $display("FAIL branch_flush: got %b want %b", outv, OFl);
    else n_pass++;
    exMemRead = 1'b1; exRt = 5'd9; idRs = 5'd9;
    #1;
    n_checks++;
    if (outv !== OLu) $display("FAIL branch_vs_load_use: got %b want %b", outv, OLu);
    else n_pass++;
    memBusy = 1'b1;
    #1;
    n_checks++;
    if (outv !== OFrz) $display("FAIL branch_vs_freeze: got %b want %b", outv, OFrz);
    else n_pass++;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_wait_restart();
    for (int c = 1; c <= 31; c++) begin
      memBusy = (c != 16);
      tick();
    end
    memBusy = 1'b1;
    #1;
    n_checks++;
    if (outv !== OFrz) $display("FAIL restart_no_timeout: got %b want %b", outv, OFrz);
    else n_pass++;
    memBusy = 1'b0;
    #1;
    n_checks++;
    if (outv !== ONone) $display("FAIL restart_release: got %b want %b", outv, ONone);
    else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    for (int c = 1; c <= 20; c++) begin
      memBusy = 1'b1;
      #1;
      n_checks++;
      if (outv !== ((c >= 17) ? OTo : OFrz)) begin
        $display("FAIL timeout_cycle%0d: got %b want %b", c, outv, (c >= 17) ? OTo : OFrz);
        bad++;
      end else n_pass++;
      tick();
    end
    memBusy = 1'b0; branchTaken = 1'b1;
    #1;
    n_checks++;
    if (outv !== OTo) $display("FAIL timeout_sticky: got %b want %b", outv, OTo);
    else n_pass++;
    tick();
    tick();
    #1;
    n_checks++;
    if (outv !== OTo) $display("FAIL timeout_held: got %b want %b", outv, OTo);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if (outv !== ONone) $display("FAIL timeout_in_reset: got %b want %b", outv, ONone);
    else n_pass++;
    tick();
    rst = 1'b0; branchTaken = 1'b0;
    #1;
    n_checks++;
    if (outv !== ONone) $display("FAIL timeout_after_reset: got %b want %b", outv, ONone);
    else n_pass++;
    n_checks++;
    if (stallCnt !== 32'd0) $display("FAIL stallcnt_after_reset: got %0d want 0", stallCnt);
    else n_pass++;
    memBusy = 1'b1;
    tick();
    memBusy = 1'b0;
    #1;
    n_checks++;
    if (outv !== ONone) $display("FAIL run_after_reset: got %b want %b", outv, ONone);
    else n_pass++;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_load_use();
    test_mem_wait_short();
    test_no_stall();
    test_branch();
    test_wait_restart();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
